// File: rtl/pipe_memory_responder_pkg.sv
// Shared definitions for the pipe memory responder.
// - state_t: responder FSM encoding (IDLE/REQUEST/DONE/FAULT)
// - FUNCT3_*: load-type codes taken from the instruction funct3 field
package pipe_memory_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        DONE    = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

endpackage

// File: rtl/pipe_memory_responder_if.sv
// Wishbone-classic bus between the responder (master) and memory (slave).
// - wb_cyc_o/wb_stb_o/wb_we_o/wb_sel_o/wb_adr_o/wb_data_o: master -> slave
// - wb_data_i/wb_ack_i/wb_err_i: slave -> master
interface pipe_memory_responder_if;

    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_data_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_data_o,
        input  wb_data_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_data_o,
        output wb_data_i, wb_ack_i, wb_err_i
    );

endinterface

// File: rtl/pipe_memory_responder_load_data_formatter.sv
// Combinational load formatter: shifts the bus word down to the addressed
// byte and sign/zero-extends according to the load type.
// - rawData       in  32  word as returned by the bus
// - byteOffset    in  2   byte offset of the load within the word
// - funct3        in  3   load type
// - formattedData out 32  value written back to the register file
module pipe_memory_responder_load_data_formatter
    import pipe_memory_responder_pkg::*;
(
    input  logic [31:0] rawData,
    input  logic [1:0]  byteOffset,
    input  logic [2:0]  funct3,
    output logic [31:0] formattedData
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rawData >> {byteOffset, 3'b000};
        case (funct3)
            FUNCT3_LB:  formattedData = {{24{shifted[7]}}, shifted[7:0]};
            FUNCT3_LH:  formattedData = {{16{shifted[15]}}, shifted[15:0]};
            FUNCT3_LW:  formattedData = shifted;
            FUNCT3_LBU: formattedData = {24'h0, shifted[7:0]};
            FUNCT3_LHU: formattedData = {16'h0, shifted[15:0]};
            default:    formattedData = 32'h0;
        endcase
    end

endmodule

// File: rtl/pipe_memory_responder.sv
// Responder for the pipe's load/store request. Runs one Wishbone-classic
// cycle per request, stalls the pipe until it completes, and holds the
// result until the pipe steps so a held request is never re-issued.
// - clk, rst            clock, asynchronous active-high reset
// - stepPipe            pipe advancing; releases DONE/FAULT
// - memory*             request from the pipe (sampled on IDLE->REQUEST)
// - memoryBusy          stall to the pipe
// - loadData/loadValid  formatted load result, held until released
// - accessFault         bus error or timeout for the current request
// - bus                 Wishbone master port
module pipe_memory_responder
    import pipe_memory_responder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stepPipe,
    input  logic        memoryEnable,
    input  logic        memoryWriteEnable,
    input  logic [3:0]  memoryByteSelect,
    input  logic [31:0] memoryAddress,
    input  logic [31:0] memoryWriteData,
    input  logic [2:0]  memoryFunct3,
    input  logic [1:0]  memoryByteOffset,
    output logic        memoryBusy,
    output logic [31:0] loadData,
    output logic        loadValid,
    output logic        accessFault,
    pipe_memory_responder_if.master bus
);

    // Keep at least one bit so a disabled timeout still elaborates.
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            cyc_q, we_q;
    logic [3:0]      sel_q;
    logic [31:0]     adr_q, wdata_q;
    logic [2:0]      funct3_q;
    logic [1:0]      offset_q;
    logic            abandoned_q;   // pipe dropped the request while on the bus
    logic [31:0]     load_data_q;
    logic            load_valid_q, fault_q;
    logic [31:0]     formatted;
    logic            keep_result;

    pipe_memory_responder_load_data_formatter u_load_data_formatter (
        .rawData      (bus.wb_data_i),
        .byteOffset   (offset_q),
        .funct3       (funct3_q),
        .formattedData(formatted)
    );

    assign keep_result = memoryEnable && !abandoned_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (memoryEnable) state_d = REQUEST;
            end
            REQUEST: begin
                // Err takes priority over ack; an abandoned request ends in IDLE.
                if (bus.wb_err_i) begin
                    state_d = keep_result ? FAULT : IDLE;
                end else if (bus.wb_ack_i) begin
                    state_d = keep_result ? DONE : IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (TIMEOUT_CYCLES != 0 && cnt_d == CntW'(TIMEOUT_CYCLES)) begin
                        state_d = keep_result ? FAULT : IDLE;
                    end
                end
            end
            DONE, FAULT: begin
                if (stepPipe || !memoryEnable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered bus and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            adr_q        <= '0;
            wdata_q      <= '0;
            funct3_q     <= '0;
            offset_q     <= '0;
            abandoned_q  <= 1'b0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (memoryEnable) begin
                        cyc_q       <= 1'b1;
                        we_q        <= memoryWriteEnable;
                        sel_q       <= memoryByteSelect;
                        adr_q       <= memoryAddress;
                        wdata_q     <= memoryWriteData;
                        funct3_q    <= memoryFunct3;
                        offset_q    <= memoryByteOffset;
                        abandoned_q <= 1'b0;
                    end
                end
                REQUEST: begin
                    if (!memoryEnable) abandoned_q <= 1'b1;
                    if (state_d != REQUEST) begin
                        cyc_q <= 1'b0;
                        we_q  <= 1'b0;
                        sel_q <= '0;
                    end
                    if (state_d == DONE && !we_q) begin
                        load_data_q  <= formatted;
                        load_valid_q <= 1'b1;
                    end
                    if (state_d == FAULT) fault_q <= 1'b1;
                end
                default: begin
                    if (state_d == IDLE) begin
                        load_valid_q <= 1'b0;
                        fault_q      <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Output logic; busy is forced low while reset is held.
    always_comb begin
        memoryBusy = !rst && ((state_q == IDLE && memoryEnable) || state_q == REQUEST);
    end

    assign bus.wb_cyc_o  = cyc_q;
    assign bus.wb_stb_o  = cyc_q;
    assign bus.wb_we_o   = we_q;
    assign bus.wb_sel_o  = sel_q;
    assign bus.wb_adr_o  = adr_q;
    assign bus.wb_data_o = wdata_q;
    assign loadData      = load_data_q;
    assign loadValid     = load_valid_q;
    assign accessFault   = fault_q;

endmodule

// File: tb/tb_pipe_memory_responder.sv
// Directed bench for pipe_memory_responder (TIMEOUT_CYCLES=4). Inputs change
// and outputs are sampled on the falling clock edge.
module tb_pipe_memory_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        stepPipe;
    logic        memoryEnable;
    logic        memoryWriteEnable;
    logic [3:0]  memoryByteSelect;
    logic [31:0] memoryAddress;
    logic [31:0] memoryWriteData;
    logic [2:0]  memoryFunct3;
    logic [1:0]  memoryByteOffset;
    logic        memoryBusy;
    logic [31:0] loadData;
    logic        loadValid;
    logic        accessFault;

    int checks = 0;
    int errors = 0;

    // Bus values captured on the first strobe cycle of an access
    int          stb_cycles;
    logic [31:0] obs_adr, obs_dat;
    logic [3:0]  obs_sel;
    logic        obs_we, obs_stb;

    pipe_memory_responder_if bus ();

    pipe_memory_responder #(.TIMEOUT_CYCLES(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .stepPipe         (stepPipe),
        .memoryEnable     (memoryEnable),
        .memoryWriteEnable(memoryWriteEnable),
        .memoryByteSelect (memoryByteSelect),
        .memoryAddress    (memoryAddress),
        .memoryWriteData  (memoryWriteData),
        .memoryFunct3     (memoryFunct3),
        .memoryByteOffset (memoryByteOffset),
        .memoryBusy       (memoryBusy),
        .loadData         (loadData),
        .loadValid        (loadValid),
        .accessFault      (accessFault),
        .bus              (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [2:0] f3, input logic [1:0] off);
        memoryEnable      = 1'b1;
        memoryWriteEnable = we;
        memoryByteSelect  = sel;
        memoryAddress     = adr;
        memoryWriteData   = dat;
        memoryFunct3      = f3;
        memoryByteOffset  = off;
    endtask

    // Acts as the slave: answers after ack_wait strobe cycles. Called on the
    // falling edge just after the request was driven; returns on the falling
    // edge following completion.
    task automatic do_access(input int ack_wait, input logic use_ack, input logic use_err,
                             input logic [31:0] rdata);
        bit done = 1'b0;
        stb_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.wb_cyc_o) begin
                bus.wb_ack_i = 1'b0;
                bus.wb_err_i = 1'b0;
                done = 1'b1;
                break;
            end
            stb_cycles++;
            if (stb_cycles == 1) begin
                obs_adr = bus.wb_adr_o;
                obs_dat = bus.wb_data_o;
                obs_sel = bus.wb_sel_o;
                obs_we  = bus.wb_we_o;
                obs_stb = bus.wb_stb_o;
            end
            bus.wb_data_i = rdata;
            bus.wb_ack_i  = use_ack && (stb_cycles > ack_wait);
            bus.wb_err_i  = use_err && (stb_cycles > ack_wait);
        end
        if (!done) begin
            check_eq("access_bound", 32'd0, 32'd1);
            bus.wb_ack_i = 1'b0;
            bus.wb_err_i = 1'b0;
        end
    endtask

    // Steps the pipe with the request still held: responder must go to IDLE.
    task automatic release_step(input string tag);
        stepPipe = 1'b1;
        @(negedge clk);
        stepPipe = 1'b0;
        check_eq({tag, "_rel_valid"}, {31'd0, loadValid}, 32'd0);
        check_eq({tag, "_rel_fault"}, {31'd0, accessFault}, 32'd0);
        check_eq({tag, "_rel_idle_busy"}, {31'd0, memoryBusy}, 32'd1);
        memoryEnable = 1'b0;
        @(negedge clk);
        check_eq({tag, "_rel_cyc"}, {31'd0, bus.wb_cyc_o}, 32'd0);
    endtask

    // Holds the request without stepping and counts any re-issued strobes.
    task automatic hold_no_step(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.wb_stb_o) seen++;
        end
        check_eq({tag, "_reissue"}, seen, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        stepPipe = 1'b0;
        memoryEnable = 1'b0;
        memoryWriteEnable = 1'b0;
        memoryByteSelect = '0;
        memoryAddress = '0;
        memoryWriteData = '0;
        memoryFunct3 = '0;
        memoryByteOffset = '0;
        bus.wb_data_i = '0;
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
        check_eq("rst_busy", {31'd0, memoryBusy}, 32'd0);
        check_eq("rst_valid", {31'd0, loadValid}, 32'd0);
        check_eq("rst_fault", {31'd0, accessFault}, 32'd0);
        check_eq("rst_data", loadData, 32'd0);
        check_eq("rst_adr", bus.wb_adr_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // LW, ack on the third strobe cycle
        issue(1'b0, 4'b1111, 32'h1000_0004, 32'h0, 3'b010, 2'd0);
        #1 check_eq("lw_busy_issue", {31'd0, memoryBusy}, 32'd1);
        do_access(2, 1'b1, 1'b0, 32'hDEAD_BEEF);
        check_eq("lw_stb_cycles", stb_cycles, 32'd3);
        check_eq("lw_adr", obs_adr, 32'h1000_0004);
        check_eq("lw_sel", {28'd0, obs_sel}, 32'hF);
        check_eq("lw_we", {31'd0, obs_we}, 32'd0);
        check_eq("lw_stb", {31'd0, obs_stb}, 32'd1);
        check_eq("lw_data", loadData, 32'hDEAD_BEEF);
        check_eq("lw_valid", {31'd0, loadValid}, 32'd1);
        check_eq("lw_busy_done", {31'd0, memoryBusy}, 32'd0);
        check_eq("lw_fault", {31'd0, accessFault}, 32'd0);
        hold_no_step("lw", 3);
        check_eq("lw_valid_held", {31'd0, loadValid}, 32'd1);
        release_step("lw");

        // LB offset 3, minimum latency
        issue(1'b0, 4'b1000, 32'h2000_0000, 32'h0, 3'b000, 2'd3);
        do_access(0, 1'b1, 1'b0, 32'h8012_3456);
        check_eq("lb_stb_cycles", stb_cycles, 32'd1);
        check_eq("lb_data", loadData, 32'hFFFF_FF80);
        check_eq("lb_valid", {31'd0, loadValid}, 32'd1);
        release_step("lb");

        // LBU same access
        issue(1'b0, 4'b1000, 32'h2000_0000, 32'h0, 3'b100, 2'd3);
        do_access(0, 1'b1, 1'b0, 32'h8012_3456);
        check_eq("lbu_data", loadData, 32'h0000_0080);
        release_step("lbu");

        // LH offset 2 (sign) and LHU offset 0
        issue(1'b0, 4'b1100, 32'h2000_0008, 32'h0, 3'b001, 2'd2);
        do_access(0, 1'b1, 1'b0, 32'h9ABC_1234);
        check_eq("lh_data", loadData, 32'hFFFF_9ABC);
        release_step("lh");
        issue(1'b0, 4'b0011, 32'h2000_0008, 32'h0, 3'b101, 2'd0);
        do_access(0, 1'b1, 1'b0, 32'h1234_F00D);
        check_eq("lhu_data", loadData, 32'h0000_F00D);
        release_step("lhu");

        // SH offset 2, held 5 cycles without stepPipe
        issue(1'b1, 4'b1100, 32'h3000_0000, 32'hBEEF_0000, 3'b001, 2'd2);
        do_access(0, 1'b1, 1'b0, 32'h0);
        check_eq("sh_stb_cycles", stb_cycles, 32'd1);
        check_eq("sh_we", {31'd0, obs_we}, 32'd1);
        check_eq("sh_sel", {28'd0, obs_sel}, 32'hC);
        check_eq("sh_wdata", obs_dat, 32'hBEEF_0000);
        check_eq("sh_valid", {31'd0, loadValid}, 32'd0);
        check_eq("sh_busy", {31'd0, memoryBusy}, 32'd0);
        hold_no_step("sh", 5);
        check_eq("sh_data_kept", loadData, 32'h0000_00F0 + 32'h0000_F000 - 32'h0000_00F0 + 32'h0D);
        release_step("sh");

        // LW with err
        issue(1'b0, 4'b1111, 32'h4000_0000, 32'h0, 3'b010, 2'd0);
        do_access(1, 1'b0, 1'b1, 32'h1111_1111);
        check_eq("err_fault", {31'd0, accessFault}, 32'd1);
        check_eq("err_valid", {31'd0, loadValid}, 32'd0);
        check_eq("err_busy", {31'd0, memoryBusy}, 32'd0);
        release_step("err");

        // err and ack together: err wins
        issue(1'b0, 4'b1111, 32'h4000_0004, 32'h0, 3'b010, 2'd0);
        do_access(0, 1'b1, 1'b1, 32'h2222_2222);
        check_eq("errack_fault", {31'd0, accessFault}, 32'd1);
        check_eq("errack_valid", {31'd0, loadValid}, 32'd0);
        release_step("errack");

        // No response: timeout after 4 REQUEST cycles
        issue(1'b0, 4'b1111, 32'h5000_0000, 32'h0, 3'b010, 2'd0);
        do_access(0, 1'b0, 1'b0, 32'h0);
        check_eq("to_stb_cycles", stb_cycles, 32'd4);
        check_eq("to_fault", {31'd0, accessFault}, 32'd1);
        check_eq("to_busy", {31'd0, memoryBusy}, 32'd0);
        release_step("to");

        // Reset mid-REQUEST
        issue(1'b0, 4'b1111, 32'h6000_0000, 32'h0, 3'b010, 2'd0);
        @(negedge clk);
        check_eq("rstmid_cyc_before", {31'd0, bus.wb_cyc_o}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rstmid_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
        check_eq("rstmid_stb", {31'd0, bus.wb_stb_o}, 32'd0);
        check_eq("rstmid_busy", {31'd0, memoryBusy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_access(0, 1'b1, 1'b0, 32'h1234_5678);
        check_eq("rstmid_new_adr", obs_adr, 32'h6000_0000);
        check_eq("rstmid_new_data", loadData, 32'h1234_5678);
        release_step("rstmid");

        // memoryEnable dropped mid-REQUEST; ack later must be discarded
        issue(1'b0, 4'b1111, 32'h7000_0000, 32'h0, 3'b010, 2'd0);
        @(negedge clk);
        memoryEnable = 1'b0;
        @(negedge clk);
        check_eq("drop_cyc_kept", {31'd0, bus.wb_cyc_o}, 32'd1);
        check_eq("drop_busy", {31'd0, memoryBusy}, 32'd1);
        bus.wb_data_i = 32'hCAFE_F00D;
        bus.wb_ack_i = 1'b1;
        @(negedge clk);
        bus.wb_ack_i = 1'b0;
        check_eq("drop_cyc_end", {31'd0, bus.wb_cyc_o}, 32'd0);
        check_eq("drop_valid", {31'd0, loadValid}, 32'd0);
        @(negedge clk);
        check_eq("drop_valid_later", {31'd0, loadValid}, 32'd0);
        issue(1'b0, 4'b1111, 32'h7000_0010, 32'h0, 3'b010, 2'd0);
        #1 check_eq("drop_idle_busy", {31'd0, memoryBusy}, 32'd1);
        do_access(0, 1'b1, 1'b0, 32'h0BAD_CAFE);
        check_eq("drop_next_data", loadData, 32'h0BAD_CAFE);
        release_step("drop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
